// File: rtl/i2c_slave_byte_ctrl.sv
`timescale 1ns/1ps
// I2C target byte controller: filters SCL/SDA, detects START/STOP, matches a
// 7-bit address and moves bytes through a valid/request handshake.
module i2c_slave_byte_ctrl #(
    parameter int FILTER_LEN = 3,
    parameter bit STRETCH_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [6:0] slave_addr,
    input  logic       scl_i,
    output logic       scl_oen,
    input  logic       sda_i,
    output logic       sda_oen,
    input  logic       rx_ack_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_req,
    output logic       addr_hit,
    output logic       rw,
    output logic       start_det,
    output logic       stop_det,
    output logic       busy,
    output logic       tx_nack
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX_WAIT, TX, TX_ACK, IGNORE
    } state_t;

    logic [1:0] pad_in, filt, filt_dly;
    assign pad_in = {sda_i, scl_i};

    // Index 0 is SCL, index 1 is SDA; both paths have identical latency.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_filt
            logic       sync1_q, sync2_q, filt_q, dly_q;
            logic [2:0] cnt_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_q <= 1'b1;
                    sync2_q <= 1'b1;
                    filt_q  <= 1'b1;
                    dly_q   <= 1'b1;
                    cnt_q   <= '0;
                end else begin
                    sync1_q <= pad_in[gi];
                    sync2_q <= sync1_q;
                    dly_q   <= filt_q;
                    if (sync2_q == filt_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == 3'(FILTER_LEN - 1)) begin
                        filt_q <= sync2_q;
                        cnt_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
            end
            assign filt[gi]     = filt_q;
            assign filt_dly[gi] = dly_q;
        end
    endgenerate

    logic scl_f, sda_f, scl_rise, scl_fall, start_cond, stop_cond;
    assign scl_f      = filt[0];
    assign sda_f      = filt[1];
    assign scl_rise   = filt[0] & ~filt_dly[0];
    assign scl_fall   = ~filt[0] & filt_dly[0];
    assign start_cond = scl_f & ~sda_f & filt_dly[1];
    assign stop_cond  = scl_f & sda_f & ~filt_dly[1];

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] sh_q, sh_d, rx_data_q, rx_data_d, buf_q, buf_d;
    logic       ack_ph_q, ack_ph_d, rx_pend_q, rx_pend_d, rx_valid_q;
    logic       rw_q, rw_d, busy_q, busy_d, sda_oen_q, sda_oen_d, scl_oen_q, scl_oen_d;
    logic       buf_full_q, buf_full_d, tx_req_q, tx_req_d, addr_hit_q, addr_hit_d;
    logic       start_det_q, start_det_d, stop_det_q, stop_det_d, tx_nack_q, tx_nack_d;
    logic       launch, tx_accept;

    assign tx_accept = tx_valid && (state_q inside {TX_WAIT, TX, TX_ACK});

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sh_d        = sh_q;
        ack_ph_d    = ack_ph_q;
        rx_data_d   = rx_data_q;
        rx_pend_d   = 1'b0;
        rw_d        = rw_q;
        busy_d      = busy_q;
        sda_oen_d   = sda_oen_q;
        scl_oen_d   = scl_oen_q;
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        tx_req_d    = 1'b0;
        addr_hit_d  = 1'b0;
        start_det_d = 1'b0;
        stop_det_d  = 1'b0;
        tx_nack_d   = 1'b0;
        launch      = 1'b0;

        if (stop_cond) begin
            busy_d     = 1'b0;
            stop_det_d = 1'b1;
        end else if (start_cond) begin
            busy_d      = 1'b1;
            start_det_d = 1'b1;
        end
        if (tx_accept) begin
            buf_d      = tx_data;
            buf_full_d = 1'b1;
        end

        if (!ena || stop_cond) begin
            state_d    = IDLE;
            sda_oen_d  = 1'b1;
            scl_oen_d  = 1'b1;
            buf_full_d = 1'b0;
        end else if (start_cond) begin
            state_d    = ADDR;
            bit_cnt_d  = '0;
            sda_oen_d  = 1'b1;
            scl_oen_d  = 1'b1;
            buf_full_d = 1'b0;
        end else begin
            case (state_q)
                ADDR: if (scl_rise) begin
                    sh_d      = {sh_q[6:0], sda_f};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (sh_q[6:0] == slave_addr) begin
                            rw_d       = sda_f;
                            addr_hit_d = 1'b1;
                            tx_req_d   = sda_f;
                            ack_ph_d   = 1'b0;
                            state_d    = ADDR_ACK;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                ADDR_ACK, RX_ACK: if (scl_fall) begin
                    if (!ack_ph_q) begin
                        ack_ph_d  = 1'b1;
                        sda_oen_d = (state_q == ADDR_ACK) ? 1'b0 : ~rx_ack_en;
                    end else begin
                        sda_oen_d = 1'b1;
                        bit_cnt_d = '0;
                        if (state_q == ADDR_ACK && rw_q) launch = 1'b1;
                        else                             state_d = RX;
                    end
                end
                RX: if (scl_rise) begin
                    sh_d      = {sh_q[6:0], sda_f};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d = {sh_q[6:0], sda_f};
                        rx_pend_d = 1'b1;
                        ack_ph_d  = 1'b0;
                        state_d   = RX_ACK;
                    end
                end
                // A stretched wait ends as soon as a byte is buffered.
                TX_WAIT: if (scl_fall || (!scl_oen_q && buf_full_q)) launch = 1'b1;
                TX: begin
                    if (!scl_oen_q) scl_oen_d = 1'b1;
                    if (scl_fall) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            sda_oen_d = 1'b1;
                            state_d   = TX_ACK;
                        end else begin
                            sh_d      = {sh_q[6:0], 1'b0};
                            sda_oen_d = sh_q[6];
                        end
                    end
                end
                TX_ACK: if (scl_rise) begin
                    if (!sda_f) begin
                        tx_req_d = 1'b1;
                        state_d  = TX_WAIT;
                    end else begin
                        tx_nack_d = 1'b1;
                        state_d   = IGNORE;
                    end
                end
                default: ;
            endcase

            // Start of a transmitted byte: use the buffer, stretch, or underrun.
            if (launch) begin
                bit_cnt_d = '0;
                if (buf_full_q) begin
                    sh_d       = buf_q;
                    sda_oen_d  = buf_q[7];
                    buf_full_d = tx_accept;
                    state_d    = TX;
                end else if (STRETCH_EN) begin
                    scl_oen_d = 1'b0;
                    state_d   = TX_WAIT;
                end else begin
                    sh_d      = 8'hFF;
                    sda_oen_d = 1'b1;
                    state_d   = TX;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            sh_q        <= '0;
            ack_ph_q    <= 1'b0;
            rx_data_q   <= '0;
            rx_pend_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            rw_q        <= 1'b0;
            busy_q      <= 1'b0;
            sda_oen_q   <= 1'b1;
            scl_oen_q   <= 1'b1;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            addr_hit_q  <= 1'b0;
            start_det_q <= 1'b0;
            stop_det_q  <= 1'b0;
            tx_nack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sh_q        <= sh_d;
            ack_ph_q    <= ack_ph_d;
            rx_data_q   <= rx_data_d;
            rx_pend_q   <= rx_pend_d;
            rx_valid_q  <= rx_pend_q;
            rw_q        <= rw_d;
            busy_q      <= busy_d;
            sda_oen_q   <= sda_oen_d;
            scl_oen_q   <= scl_oen_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
            tx_req_q    <= tx_req_d;
            addr_hit_q  <= addr_hit_d;
            start_det_q <= start_det_d;
            stop_det_q  <= stop_det_d;
            tx_nack_q   <= tx_nack_d;
        end
    end

    assign scl_oen   = scl_oen_q;
    assign sda_oen   = sda_oen_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign tx_req    = tx_req_q;
    assign addr_hit  = addr_hit_q;
    assign rw        = rw_q;
    assign start_det = start_det_q;
    assign stop_det  = stop_det_q;
    assign busy      = busy_q;
    assign tx_nack   = tx_nack_q;
endmodule

// File: tb/tb_i2c_slave_byte_ctrl.sv
`timescale 1ns/1ps
// Bench for i2c_slave_byte_ctrl: a cycle-timed I2C master on a wired-AND bus,
// a delayed tx responder, a write-vector table and hand-written read sequences.
module tb_i2c_slave_byte_ctrl;
    localparam int H        = 12;
    localparam int RESP_DLY = 50;

    logic       clk = 1'b0;
    logic       rst, ena, rx_ack_en, tx_valid;
    logic [6:0] slave_addr;
    logic [7:0] tx_data, rx_data;
    logic       scl_oen, sda_oen, rx_valid, tx_req, addr_hit, rw;
    logic       start_det, stop_det, busy, tx_nack;
    logic       scl_m, sda_m, scl_line, sda_line;

    assign scl_line = scl_m & scl_oen;
    assign sda_line = sda_m & sda_oen;

    always #5 clk = ~clk;

    i2c_slave_byte_ctrl #(.FILTER_LEN(3), .STRETCH_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .ena(ena), .slave_addr(slave_addr),
        .scl_i(scl_line), .scl_oen(scl_oen), .sda_i(sda_line), .sda_oen(sda_oen),
        .rx_ack_en(rx_ack_en), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_req(tx_req),
        .addr_hit(addr_hit), .rw(rw), .start_det(start_det), .stop_det(stop_det),
        .busy(busy), .tx_nack(tx_nack)
    );

    int n_chk = 0;
    int n_fail = 0;
    int hit_cnt, start_cnt, stop_cnt, txreq_cnt, nack_cnt;
    logic sda_low_seen, stretch_seen;
    logic [7:0] rxq[$];
    logic [7:0] txq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        hit_cnt = 0; start_cnt = 0; stop_cnt = 0; txreq_cnt = 0; nack_cnt = 0;
        sda_low_seen = 1'b0; stretch_seen = 1'b0;
        rxq.delete();
    endtask

    task automatic wait_high();
        int k = 0;
        while (scl_line !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 2000) begin
            n_chk++;
            n_fail++;
            $display("FAIL scl_timeout: got SCL stuck low required release within 2000 cycles");
        end
    endtask

    task automatic scl_pulse(output logic s);
        scl_m = 1'b1;
        wait_high();
        wait_cyc(H / 2);
        s = sda_line;
        wait_cyc(H / 2);
        scl_m = 1'b0;
        wait_cyc(2);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wait_cyc(H);
        scl_m = 1'b1; wait_high(); wait_cyc(H);
        sda_m = 1'b0; wait_cyc(H);
        scl_m = 1'b0; wait_cyc(H);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_cyc(H);
        scl_m = 1'b1; wait_high(); wait_cyc(H);
        sda_m = 1'b1; wait_cyc(H);
    endtask

    task automatic write_byte(input logic [7:0] b, input int nbits, output logic ack);
        logic s;
        for (int i = 7; i >= 8 - nbits; i--) begin
            sda_m = b[i];
            wait_cyc(H);
            scl_pulse(s);
        end
        ack = 1'b1;
        if (nbits == 8) begin
            sda_m = 1'b1;
            wait_cyc(H);
            scl_pulse(ack);
        end
        $display("master write %02h (%0d bits) ack_line=%0b", b, nbits, ack);
    endtask

    task automatic read_byte(input logic ack_bit, output logic [7:0] b);
        logic s;
        sda_m = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            wait_cyc(H);
            scl_pulse(s);
            b[i] = s;
        end
        sda_m = ack_bit;
        wait_cyc(H);
        scl_pulse(s);
        $display("master read %02h master_ack=%0b", b, ack_bit);
    endtask

    // Event monitor, sampled on the falling clock edge.
    initial begin
        clear_mon();
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (addr_hit)  hit_cnt++;
                if (start_det) start_cnt++;
                if (stop_det)  stop_cnt++;
                if (tx_req)    txreq_cnt++;
                if (tx_nack)   nack_cnt++;
                if (sda_oen === 1'b0) sda_low_seen = 1'b1;
                if (scl_oen === 1'b0) stretch_seen = 1'b1;
                if (rx_valid) rxq.push_back(rx_data);
            end
        end
    end

    // Register-file side: answers each tx_req RESP_DLY cycles later.
    initial begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (tx_req) begin
                int k;
                wait_cyc(RESP_DLY);
                tx_data = 8'h00;
                if (txq.size() > 0) tx_data = txq.pop_front();
                chk("stretch_held", scl_oen, 1'b0);
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
                k = 0;
                while (scl_oen === 1'b0 && k < 6) begin
                    @(negedge clk);
                    k++;
                end
                chk("stretch_release", scl_oen, 1'b1);
                $display("tx load %02h", tx_data);
            end
        end
    end

    initial begin
        #400us;
        $display("FAIL watchdog: got no finish required finish before 400us");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       ack_en;
        logic       hit;
        logic [2:0] acks;
    } wvec_t;

    wvec_t vec[4];
    localparam logic [17:0] RST_VAL = {2'b11, 16'h0000};

    initial begin
        logic k0, k1, k2;
        logic [7:0] b0, b1;

        vec[0] = '{8'hA0, 8'h3C, 8'hC3, 1'b1, 1'b1, 3'b000};
        vec[1] = '{8'hA2, 8'h3C, 8'hC3, 1'b1, 1'b0, 3'b111};
        vec[2] = '{8'hA0, 8'h55, 8'hAA, 1'b0, 1'b1, 3'b011};
        vec[3] = '{8'hA0, 8'h00, 8'hFF, 1'b1, 1'b1, 3'b000};

        rst = 1'b1; ena = 1'b1; slave_addr = 7'h50; rx_ack_en = 1'b1;
        scl_m = 1'b1; sda_m = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(1);
        chk("reset_outputs", {scl_oen, sda_oen, rx_data, rx_valid, tx_req, addr_hit,
                              rw, start_det, stop_det, busy, tx_nack}, RST_VAL);
        wait_cyc(10);

        for (int i = 0; i < 4; i++) begin
            clear_mon();
            rx_ack_en = vec[i].ack_en;
            bus_start();
            chk("w_busy_after_start", busy, 1'b1);
            write_byte(vec[i].a, 8, k0);
            write_byte(vec[i].d0, 8, k1);
            write_byte(vec[i].d1, 8, k2);
            bus_stop();
            wait_cyc(10);
            chk("w_ack_lines", {k0, k1, k2}, vec[i].acks);
            chk("w_addr_hit", hit_cnt, vec[i].hit ? 1 : 0);
            chk("w_rx_count", rxq.size(), vec[i].hit ? 2 : 0);
            if (rxq.size() == 2) begin
                chk("w_rx_data0", rxq[0], vec[i].d0);
                chk("w_rx_data1", rxq[1], vec[i].d1);
            end
            chk("w_start_stop", {start_cnt[7:0], stop_cnt[7:0]}, 16'h0101);
            chk("w_busy_after_stop", busy, 1'b0);
            chk("w_sda_driven", sda_low_seen, vec[i].hit);
            chk("w_rw", rw, 1'b0);
            $display("write vector %0d addr=%02h done", i, vec[i].a);
        end

        // Single-byte read with stretch and master NACK.
        clear_mon();
        txq.push_back(8'h96);
        bus_start();
        write_byte(8'hA1, 8, k0);
        chk("r1_addr_ack", k0, 1'b0);
        chk("r1_rw", rw, 1'b1);
        chk("r1_tx_req", txreq_cnt, 1);
        read_byte(1'b1, b0);
        wait_cyc(2);
        chk("r1_data", b0, 8'h96);
        chk("r1_tx_nack", nack_cnt, 1);
        chk("r1_stretched", stretch_seen, 1'b1);
        chk("r1_sda_released", sda_oen, 1'b1);
        bus_stop();
        wait_cyc(10);
        chk("r1_stop", stop_cnt, 1);
        chk("r1_busy", busy, 1'b0);

        // Two-byte read: ACK then NACK.
        clear_mon();
        txq.push_back(8'h12);
        txq.push_back(8'h34);
        bus_start();
        write_byte(8'hA1, 8, k0);
        read_byte(1'b0, b0);
        read_byte(1'b1, b1);
        bus_stop();
        wait_cyc(10);
        chk("r2_bytes", {b0, b1}, 16'h1234);
        chk("r2_tx_req", txreq_cnt, 2);
        chk("r2_tx_nack", nack_cnt, 1);

        // Repeated START from write into read.
        clear_mon();
        txq.push_back(8'h5A);
        rx_ack_en = 1'b1;
        bus_start();
        write_byte(8'hA0, 8, k0);
        write_byte(8'h01, 8, k1);
        chk("sr_rw_before", rw, 1'b0);
        bus_start();
        write_byte(8'hA1, 8, k2);
        chk("sr_acks", {k0, k1, k2}, 3'b000);
        chk("sr_starts", start_cnt, 2);
        chk("sr_no_stop", stop_cnt, 0);
        chk("sr_rw_after", rw, 1'b1);
        chk("sr_tx_req", txreq_cnt, 1);
        chk("sr_rx_count", rxq.size(), 1);
        if (rxq.size() == 1) chk("sr_rx_data", rxq[0], 8'h01);
        read_byte(1'b1, b0);
        chk("sr_read", b0, 8'h5A);
        bus_stop();
        wait_cyc(10);

        // Reset in the middle of a received byte.
        clear_mon();
        bus_start();
        write_byte(8'hA0, 8, k0);
        write_byte(8'hF0, 4, k1);
        chk("mr_busy_before", busy, 1'b1);
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        chk("mr_reset_outputs", {scl_oen, sda_oen, rx_data, rx_valid, tx_req, addr_hit,
                                 rw, start_det, stop_det, busy, tx_nack}, RST_VAL);
        sda_m = 1'b1; wait_cyc(H);
        scl_m = 1'b1; wait_cyc(3 * H);
        clear_mon();
        bus_start();
        write_byte(8'hA0, 8, k0);
        write_byte(8'h77, 8, k1);
        bus_stop();
        wait_cyc(10);
        chk("mr_acks", {k0, k1}, 2'b00);
        chk("mr_addr_hit", hit_cnt, 1);
        chk("mr_rx_count", rxq.size(), 1);
        if (rxq.size() == 1) chk("mr_rx_data", rxq[0], 8'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_slave_byte_ctrl.md
Name: i2c_slave_byte_ctrl

Overview:
- Byte-level I2C target (slave) controller: the responder end of the I2C master byte/bit controller pair.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a 7-bit address, ACKs it, then receives or transmits bytes through a simple valid/request handshake to the register-file side.
- Optional SCL clock stretching while transmit data is not yet available.

Parameters:
- FILTER_LEN, 3: consecutive identical synchronized samples needed before a filtered SCL/SDA level changes (1..7).
- STRETCH_EN, 1: 1 = hold SCL low while waiting for tx data; 0 = never drive SCL; send 8'hFF on underrun.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- ena  in  1  core enable; 0 forces IDLE and releases both lines
- slave_addr  in  7  own address, sampled when the address byte completes
- scl_i  in  1  SCL pad input
- scl_oen  out  1  SCL output enable, active-low (0 = drive low)
- sda_i  in  1  SDA pad input
- sda_oen  out  1  SDA output enable, active-low
- rx_ack_en  in  1  1 = ACK a received data byte; 0 = NACK it
- rx_data  out  8  last received data byte
- rx_valid  out  1  one-cycle pulse; rx_data is valid
- tx_data  in  8  byte to transmit
- tx_valid  in  1  one-cycle pulse; tx_data is accepted
- tx_req  out  1  one-cycle pulse; controller needs the next tx byte
- addr_hit  out  1  one-cycle pulse on address match
- rw  out  1  R/W bit of the current transfer (1 = master reads)
- start_det  out  1  one-cycle pulse on START or repeated START
- stop_det  out  1  one-cycle pulse on STOP
- busy  out  1  high from START to STOP (any address)
- tx_nack  out  1  one-cycle pulse when the master NACKs a transmitted byte

Behaviour:
- Reset (rst=1 at a clk edge): scl_oen=1, sda_oen=1, every pulse output 0, rx_data=0, rw=0, busy=0, state IDLE. The filters preset to 1 so no false edge is seen after reset.
- Input path: 2-FF synchronizer, then the FILTER_LEN-sample filter. Edge flags are derived from the filtered scl_f/sda_f, one cycle after the level change.
- START: sda_f falls while scl_f=1.
  - Enters ADDR, clears the bit counter, sets busy, pulses start_det.
  - Valid in every state, including mid-byte; it aborts the current transfer.
- STOP: sda_f rises while scl_f=1.
  - Goes to IDLE, clears busy, pulses stop_det, releases SDA and SCL.
  - Overrides all other events in the same cycle.
- Sampling and driving:
  - Data is sampled on the scl_f rising edge, MSB first.
  - sda_oen changes only on the cycle after a scl_f falling edge.
- States: IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX_WAIT, TX, TX_ACK, IGNORE.
- ADDR:
  - Shift 8 bits.
  - After the 8th rise, compare bits[7:1] with slave_addr.
  - Match: latch rw, pulse addr_hit, go to ADDR_ACK.
  - Mismatch: go to IGNORE (lines released until START/STOP).
- ADDR_ACK:
  - On the next SCL fall, drive sda_oen=0.
  - On the following fall, release SDA and go to RX (rw=0) or TX_WAIT (rw=1).
  - For rw=1, pulse tx_req on ADDR_ACK entry.
- RX:
  - After the 8th rise: rx_data updated, rx_valid pulses one cycle later, go to RX_ACK.
  - At the next SCL fall, sda_oen = ~rx_ack_en (sampled then).
  - At the following fall, release SDA and go to RX.
  - A NACKed byte still pulses rx_valid.
- TX_WAIT:
  - If tx_valid has already arrived (byte buffered), go directly to TX.
  - Otherwise, at the SCL fall ending ACK: STRETCH_EN=1 holds scl_oen=0 until tx_valid, then releases SCL the cycle after the load; STRETCH_EN=0 loads 8'hFF.
- tx_valid handling:
  - One-entry buffer; tx_valid while the buffer is full overwrites it.
  - tx_valid outside TX_WAIT/TX/TX_ACK is ignored.
- TX:
  - Bit 7 is driven before the first rise (sda_oen = bit value, i.e. 0 for a 0 bit).
  - Each SCL fall shifts to the next bit.
  - After the 8th bit's fall, release SDA and go to TX_ACK.
- TX_ACK:
  - Sample SDA on the rise.
  - 0 (ACK): pulse tx_req, go to TX_WAIT.
  - 1 (NACK): pulse tx_nack, go to IGNORE.
- ena=0: immediate IDLE with lines released; busy still tracks START/STOP.
- Lost-bus safety: the controller never drives SDA low while scl_f=1 except during the ACK bit or a data bit it is already driving.

Test Plan:
- slave_addr=7'h50; master writes START, 0xA0, 0x3C, 0xC3, STOP with rx_ack_en=1 → addr_hit once; rx_valid twice with rx_data 0x3C then 0xC3; SDA low at the three ACK bits; start_det and stop_det one pulse each; busy high between them.
- Master addresses 0x51 (slave 0x50) → no addr_hit; sda_oen stays 1 for the whole transfer; busy still high between START and STOP.
- Master reads (0xA1), tx_valid with 0x96 given 50 cycles after tx_req, STRETCH_EN=1 → scl_oen=0 until the load; the 0x96 bit pattern appears on SDA; master NACK → tx_nack pulse, state IGNORE, then stop_det.
- Read of two bytes 0x12, 0x34 with master ACK then NACK → tx_req pulses twice; tx_nack after the second byte.
- Repeated START after the write byte 0x01, then read address 0xA1 → second start_det; rw goes 1; tx_req issued; no stop_det between.
- rst pulsed mid-byte during RX → all outputs return to reset values next cycle; SDA released; next START is accepted normally.
